// File: rtl/cs_useq_pkg.sv
// cs_useq shared definitions: next-address op encodings
// and default geometry of the microsequencer.
package cs_useq_pkg;

  localparam int ADDR_W_DEF      = 11;
  localparam int STACK_DEPTH_DEF = 4;

  typedef enum logic [2:0] {
    OP_NEXT    = 3'd0,
    OP_JUMP    = 3'd1,
    OP_BR_T    = 3'd2,
    OP_BR_F    = 3'd3,
    OP_CALL    = 3'd4,
    OP_RET     = 3'd5,
    OP_HOLD    = 3'd6,
    OP_RESTART = 3'd7
  } op_e;

  function automatic int sp_width(int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/cs_useq_if.sv
// Decoder <-> microsequencer bus: op request in,
// current/next microaddress and stack status out.
interface cs_useq_if #(
  parameter int ADDR_W = 11,
  parameter int SP_W   = 3
);
  logic              CS_USEQ_ACK;
  logic [2:0]        CS_USEQ_OP;
  logic [ADDR_W-1:0] CS_USEQ_JUMP_ADDR;
  logic              CS_USEQ_COND;
  logic [ADDR_W-1:0] CS_USEQ_data_OutBUS;
  logic [ADDR_W-1:0] CS_USEQ_CSAI_OutBUS;
  logic [SP_W-1:0]   CS_USEQ_SP;
  logic              CS_USEQ_STACK_ERR;

  modport master (
    output CS_USEQ_ACK, CS_USEQ_OP,
    output CS_USEQ_JUMP_ADDR, CS_USEQ_COND,
    input  CS_USEQ_data_OutBUS, CS_USEQ_CSAI_OutBUS,
    input  CS_USEQ_SP, CS_USEQ_STACK_ERR
  );

  modport slave (
    input  CS_USEQ_ACK, CS_USEQ_OP,
    input  CS_USEQ_JUMP_ADDR, CS_USEQ_COND,
    output CS_USEQ_data_OutBUS, CS_USEQ_CSAI_OutBUS,
    output CS_USEQ_SP, CS_USEQ_STACK_ERR
  );
endinterface

// File: rtl/cs_useq_stack.sv
// Return-address LIFO; top is read combinationally
// from the register array, push/pop never together.
module cs_useq_stack #(
  parameter int ADDR_W = 11,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_data,
  output logic [ADDR_W-1:0] top,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count
);

  logic [ADDR_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] mem_d [DEPTH];
  logic [CNT_W-1:0]  count_q, count_d;

  always_comb begin
    mem_d   = mem_q;
    count_d = count_q;
    top     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (push && CNT_W'(i) == count_q)
        mem_d[i] = push_data;
      if (CNT_W'(i) + 1'b1 == count_q)
        top = mem_q[i];
    end
    if (clr)
      count_d = '0;
    else if (push)
      count_d = count_q + 1'b1;
    else if (pop)
      count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  // Entries above the count are dead; no reset needed.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/cs_useq.sv
// Control-store microsequencer: next-address select,
// registered upc and upc+1, return stack, sticky error.
module cs_useq
  import cs_useq_pkg::*;
#(
  parameter int          ADDR_W      = ADDR_W_DEF,
  parameter int          STACK_DEPTH = STACK_DEPTH_DEF,
  parameter int unsigned RESET_ADDR  = 0
) (
  input logic      CS_USEQ_CLOCK_50,
  input logic      CS_USEQ_RESET,
  cs_useq_if.slave bus
);

  localparam int SP_W = $clog2(STACK_DEPTH + 1);
  localparam logic [ADDR_W-1:0] RST_A = ADDR_W'(RESET_ADDR);
  localparam logic [ADDR_W-1:0] RST_C = RST_A + 1'b1;

  logic [ADDR_W-1:0] upc_q, upc_d;
  logic [ADDR_W-1:0] csai_q, csai_d;
  logic              err_q, err_d;
  logic              push, pop, clr;
  logic              full, empty;
  logic [ADDR_W-1:0] top;
  logic [SP_W-1:0]   sp;
  op_e               op;

  assign op = op_e'(bus.CS_USEQ_OP);

  always_comb begin
    upc_d = upc_q;
    err_d = err_q;
    push  = 1'b0;
    pop   = 1'b0;
    clr   = 1'b0;
    if (bus.CS_USEQ_ACK) begin
      unique case (op)
        OP_NEXT: upc_d = csai_q;
        OP_JUMP: upc_d = bus.CS_USEQ_JUMP_ADDR;
        OP_BR_T: upc_d = bus.CS_USEQ_COND ?
                         bus.CS_USEQ_JUMP_ADDR : csai_q;
        OP_BR_F: upc_d = bus.CS_USEQ_COND ?
                         csai_q : bus.CS_USEQ_JUMP_ADDR;
        OP_CALL: begin
          if (!full) begin
            push  = 1'b1;
            upc_d = bus.CS_USEQ_JUMP_ADDR;
          end else begin
            upc_d = csai_q;
            err_d = 1'b1;
          end
        end
        OP_RET: begin
          if (!empty) begin
            pop   = 1'b1;
            upc_d = top;
          end else begin
            upc_d = csai_q;
            err_d = 1'b1;
          end
        end
        OP_HOLD: upc_d = upc_q;
        OP_RESTART: begin
          upc_d = RST_A;
          err_d = 1'b0;
          clr   = 1'b1;
        end
      endcase
    end
    // Increment precomputed from next value: no adder after the flop.
    csai_d = upc_d + 1'b1;
  end

  always_ff @(posedge CS_USEQ_CLOCK_50) begin
    if (CS_USEQ_RESET) begin
      upc_q  <= RST_A;
      csai_q <= RST_C;
      err_q  <= 1'b0;
    end else begin
      upc_q  <= upc_d;
      csai_q <= csai_d;
      err_q  <= err_d;
    end
  end

  cs_useq_stack #(
    .ADDR_W (ADDR_W),
    .DEPTH  (STACK_DEPTH),
    .CNT_W  (SP_W)
  ) u_stack (
    .clk       (CS_USEQ_CLOCK_50),
    .rst       (CS_USEQ_RESET),
    .clr       (clr),
    .push      (push),
    .pop       (pop),
    .push_data (csai_q),
    .top       (top),
    .full      (full),
    .empty     (empty),
    .count     (sp)
  );

  assign bus.CS_USEQ_data_OutBUS = upc_q;
  assign bus.CS_USEQ_CSAI_OutBUS = csai_q;
  assign bus.CS_USEQ_SP          = sp;
  assign bus.CS_USEQ_STACK_ERR   = err_q;

endmodule

// File: tb/tb_cs_useq.sv
// Bench for cs_useq: directed scenarios plus random
// ops compared against a queue-based address model.
module tb_cs_useq;
  import cs_useq_pkg::*;

  localparam int AW   = 11;
  localparam int D    = 4;
  localparam int SPW  = $clog2(D + 1);
  localparam int MODV = 1 << AW;
  localparam int RA   = 0;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  cs_useq_if #(.ADDR_W(AW), .SP_W(SPW)) bus ();

  cs_useq #(
    .ADDR_W      (AW),
    .STACK_DEPTH (D),
    .RESET_ADDR  (RA)
  ) dut (
    .CS_USEQ_CLOCK_50 (clk),
    .CS_USEQ_RESET    (rst),
    .bus              (bus)
  );

  always #5 clk = ~clk;

  int m_upc = 0;
  int m_err = 0;
  int m_stk [$];

  task automatic model_step(input bit r, input bit ack,
                            input int op, input int ja,
                            input bit cond);
    int inc;
    inc = (m_upc + 1) % MODV;
    if (r) begin
      m_upc = RA; m_err = 0; m_stk.delete();
    end else if (ack) begin
      case (op)
        0: m_upc = inc;
        1: m_upc = ja;
        2: m_upc = cond ? ja : inc;
        3: m_upc = cond ? inc : ja;
        4: if (m_stk.size() < D) begin
             m_stk.push_back(inc); m_upc = ja;
           end else begin
             m_upc = inc; m_err = 1;
           end
        5: if (m_stk.size() > 0) begin
             m_upc = m_stk.pop_back();
           end else begin
             m_upc = inc; m_err = 1;
           end
        6: ;
        default: begin
          m_upc = RA; m_err = 0; m_stk.delete();
        end
      endcase
    end
  endtask

  task automatic cyc(input bit ack, input int op,
                     input int ja, input bit cond);
    bus.CS_USEQ_ACK       = ack;
    bus.CS_USEQ_OP        = 3'(op);
    bus.CS_USEQ_JUMP_ADDR = AW'(ja);
    bus.CS_USEQ_COND      = cond;
    @(posedge clk);
    model_step(rst, ack, op, ja, cond);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    cyc(1'b1, OP_JUMP, 'h123, 1'b0);
    rst = 1'b0;
    total++;
    if (bus.CS_USEQ_data_OutBUS !== AW'(0) ||
        bus.CS_USEQ_CSAI_OutBUS !== AW'(1) ||
        bus.CS_USEQ_SP !== SPW'(0) ||
        bus.CS_USEQ_STACK_ERR !== 1'b0) begin
      bad++;
      $display("FAIL reset: got upc=%h csai=%h sp=%0d err=%b want 000 001 0 0",
               bus.CS_USEQ_data_OutBUS, bus.CS_USEQ_CSAI_OutBUS,
               bus.CS_USEQ_SP, bus.CS_USEQ_STACK_ERR);
    end
  endtask

  task automatic test_next;
    for (int i = 1; i <= 3; i++) begin
      cyc(1'b1, OP_NEXT, 0, 1'b0);
      total++;
      if (bus.CS_USEQ_data_OutBUS !== AW'(i) ||
          bus.CS_USEQ_CSAI_OutBUS !== AW'(i + 1) ||
          bus.CS_USEQ_SP !== SPW'(0) ||
          bus.CS_USEQ_STACK_ERR !== 1'b0) begin
        bad++;
        $display("FAIL next%0d: got upc=%h csai=%h want %h %h",
                 i, bus.CS_USEQ_data_OutBUS,
                 bus.CS_USEQ_CSAI_OutBUS, i, i + 1);
      end
    end
  endtask

  task automatic test_wrap;
    cyc(1'b1, OP_JUMP, 'h7FF, 1'b0);
    total++;
    if (bus.CS_USEQ_data_OutBUS !== AW'('h7FF) ||
        bus.CS_USEQ_CSAI_OutBUS !== AW'(0)) begin
      bad++;
      $display("FAIL wrap_jump: got upc=%h csai=%h want 7ff 000",
               bus.CS_USEQ_data_OutBUS, bus.CS_USEQ_CSAI_OutBUS);
    end
    cyc(1'b1, OP_NEXT, 0, 1'b0);
    total++;
    if (bus.CS_USEQ_data_OutBUS !== AW'(0) ||
        bus.CS_USEQ_CSAI_OutBUS !== AW'(1)) begin
      bad++;
      $display("FAIL wrap_next: got upc=%h csai=%h want 000 001",
               bus.CS_USEQ_data_OutBUS, bus.CS_USEQ_CSAI_OutBUS);
    end
  endtask

  task automatic test_branch;
    cyc(1'b1, OP_JUMP, 'h010, 1'b0);
    cyc(1'b1, OP_BR_T, 'h100, 1'b0);
    total++;
    if (bus.CS_USEQ_data_OutBUS !== AW'('h011)) begin
      bad++;
      $display("FAIL br_t_not_taken: got %h want 011",
               bus.CS_USEQ_data_OutBUS);
    end
    cyc(1'b1, OP_BR_F, 'h100, 1'b0);
    total++;
    if (bus.CS_USEQ_data_OutBUS !== AW'('h100)) begin
      bad++;
      $display("FAIL br_f_taken: got %h want 100",
               bus.CS_USEQ_data_OutBUS);
    end
    cyc(1'b1, OP_BR_T, 'h222, 1'b1);
    total++;
    if (bus.CS_USEQ_data_OutBUS !== AW'('h222)) begin
      bad++;
      $display("FAIL br_t_taken: got %h want 222",
               bus.CS_USEQ_data_OutBUS);
    end
    for (int op = 0; op < 8; op++) begin
      cyc(1'b0, op, 'h555, 1'b1);
      total++;
      if (bus.CS_USEQ_data_OutBUS !== AW'('h222) ||
          bus.CS_USEQ_CSAI_OutBUS !== AW'('h223)) begin
        bad++;
        $display("FAIL ack0_op%0d: got upc=%h csai=%h want 222 223",
                 op, bus.CS_USEQ_data_OutBUS, bus.CS_USEQ_CSAI_OutBUS);
      end
    end
    cyc(1'b1, OP_HOLD, 'h555, 1'b0);
    total++;
    if (bus.CS_USEQ_data_OutBUS !== AW'('h222)) begin
      bad++;
      $display("FAIL hold: got %h want 222", bus.CS_USEQ_data_OutBUS);
    end
  endtask

  task automatic test_call_ret;
    int exp_a [4] = '{'h200, 'h300, 'h201, 'h021};
    int exp_s [4] = '{1, 2, 1, 0};
    int ops   [4] = '{4, 4, 5, 5};
    int tgt   [4] = '{'h200, 'h300, 0, 0};
    cyc(1'b1, OP_JUMP, 'h020, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, ops[i], tgt[i], 1'b0);
      total++;
      if (bus.CS_USEQ_data_OutBUS !== AW'(exp_a[i]) ||
          bus.CS_USEQ_SP !== SPW'(exp_s[i]) ||
          bus.CS_USEQ_STACK_ERR !== 1'b0) begin
        bad++;
        $display("FAIL call_ret%0d: got upc=%h sp=%0d err=%b want %h %0d 0",
                 i, bus.CS_USEQ_data_OutBUS, bus.CS_USEQ_SP,
                 bus.CS_USEQ_STACK_ERR, exp_a[i], exp_s[i]);
      end
    end
  endtask

  task automatic test_overflow;
    cyc(1'b1, OP_JUMP, 'h040, 1'b0);
    for (int i = 0; i < 4; i++)
      cyc(1'b1, OP_CALL, 'h100 + 'h10 * i, 1'b0);
    total++;
    if (bus.CS_USEQ_SP !== SPW'(4) ||
        bus.CS_USEQ_STACK_ERR !== 1'b0) begin
      bad++;
      $display("FAIL fill: got sp=%0d err=%b want 4 0",
               bus.CS_USEQ_SP, bus.CS_USEQ_STACK_ERR);
    end
    cyc(1'b1, OP_CALL, 'h140, 1'b0);
    total++;
    if (bus.CS_USEQ_data_OutBUS !== AW'('h131) ||
        bus.CS_USEQ_SP !== SPW'(4) ||
        bus.CS_USEQ_STACK_ERR !== 1'b1) begin
      bad++;
      $display("FAIL overflow: got upc=%h sp=%0d err=%b want 131 4 1",
               bus.CS_USEQ_data_OutBUS, bus.CS_USEQ_SP,
               bus.CS_USEQ_STACK_ERR);
    end
    cyc(1'b1, OP_RET, 0, 1'b0);
    total++;
    if (bus.CS_USEQ_data_OutBUS !== AW'('h121) ||
        bus.CS_USEQ_SP !== SPW'(3) ||
        bus.CS_USEQ_STACK_ERR !== 1'b1) begin
      bad++;
      $display("FAIL ret_after_ovf: got upc=%h sp=%0d err=%b want 121 3 1",
               bus.CS_USEQ_data_OutBUS, bus.CS_USEQ_SP,
               bus.CS_USEQ_STACK_ERR);
    end
  endtask

  task automatic test_underflow_restart;
    cyc(1'b1, OP_RESTART, 'h3AA, 1'b1);
    total++;
    if (bus.CS_USEQ_data_OutBUS !== AW'(RA) ||
        bus.CS_USEQ_CSAI_OutBUS !== AW'(RA + 1) ||
        bus.CS_USEQ_SP !== SPW'(0) ||
        bus.CS_USEQ_STACK_ERR !== 1'b0) begin
      bad++;
      $display("FAIL restart: got upc=%h csai=%h sp=%0d err=%b want 000 001 0 0",
               bus.CS_USEQ_data_OutBUS, bus.CS_USEQ_CSAI_OutBUS,
               bus.CS_USEQ_SP, bus.CS_USEQ_STACK_ERR);
    end
    cyc(1'b1, OP_JUMP, 'h070, 1'b0);
    cyc(1'b1, OP_RET, 0, 1'b0);
    total++;
    if (bus.CS_USEQ_data_OutBUS !== AW'('h071) ||
        bus.CS_USEQ_SP !== SPW'(0) ||
        bus.CS_USEQ_STACK_ERR !== 1'b1) begin
      bad++;
      $display("FAIL underflow: got upc=%h sp=%0d err=%b want 071 0 1",
               bus.CS_USEQ_data_OutBUS, bus.CS_USEQ_SP,
               bus.CS_USEQ_STACK_ERR);
    end
    cyc(1'b1, OP_NEXT, 0, 1'b0);
    total++;
    if (bus.CS_USEQ_STACK_ERR !== 1'b1) begin
      bad++;
      $display("FAIL err_sticky: got err=%b want 1",
               bus.CS_USEQ_STACK_ERR);
    end
  endtask

  task automatic test_reset_mid;
    cyc(1'b1, OP_JUMP, 'h050, 1'b0);
    cyc(1'b1, OP_CALL, 'h060, 1'b0);
    rst = 1'b1;
    cyc(1'b1, OP_CALL, 'h080, 1'b1);
    rst = 1'b0;
    total++;
    if (bus.CS_USEQ_data_OutBUS !== AW'(RA) ||
        bus.CS_USEQ_CSAI_OutBUS !== AW'(RA + 1) ||
        bus.CS_USEQ_SP !== SPW'(0) ||
        bus.CS_USEQ_STACK_ERR !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid: got upc=%h csai=%h sp=%0d err=%b want 000 001 0 0",
               bus.CS_USEQ_data_OutBUS, bus.CS_USEQ_CSAI_OutBUS,
               bus.CS_USEQ_SP, bus.CS_USEQ_STACK_ERR);
    end
  endtask

  task automatic test_random;
    int op, ja;
    bit ack, cond;
    for (int n = 0; n < 400; n++) begin
      ack  = ($urandom_range(0, 7) != 0);
      op   = $urandom_range(0, 7);
      if (op == 7 && $urandom_range(0, 3) != 0) op = 4;
      ja   = $urandom_range(0, MODV - 1);
      if ($urandom_range(0, 7) == 0) ja = MODV - 1;
      cond = 1'($urandom_range(0, 1));
      rst  = ($urandom_range(0, 63) == 0);
      cyc(ack, op, ja, cond);
      rst = 1'b0;
      total++;
      if (bus.CS_USEQ_data_OutBUS !== AW'(m_upc) ||
          bus.CS_USEQ_CSAI_OutBUS !== AW'((m_upc + 1) % MODV) ||
          bus.CS_USEQ_SP !== SPW'(m_stk.size()) ||
          bus.CS_USEQ_STACK_ERR !== 1'(m_err)) begin
        bad++;
        $display("FAIL random%0d: got upc=%h csai=%h sp=%0d err=%b want %h %h %0d %0d",
                 n, bus.CS_USEQ_data_OutBUS, bus.CS_USEQ_CSAI_OutBUS,
                 bus.CS_USEQ_SP, bus.CS_USEQ_STACK_ERR, m_upc,
                 (m_upc + 1) % MODV, m_stk.size(), m_err);
      end
    end
  endtask

  initial begin
    bus.CS_USEQ_ACK       = 1'b0;
    bus.CS_USEQ_OP        = 3'd0;
    bus.CS_USEQ_JUMP_ADDR = '0;
    bus.CS_USEQ_COND      = 1'b0;
    test_reset;
    test_next;
    test_wrap;
    test_branch;
    test_call_ret;
    test_overflow;
    test_underflow_restart;
    test_reset_mid;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
